// File: rtl/btn_event_classifier_pkg.sv
// Shared definitions for the button event classifier: FSM state encoding
// and default timing thresholds (cycles of a 12 MHz board clock).
package btn_event_classifier_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPressed  = 3'd1,
        StHeld     = 3'd2,
        StGap      = 3'd3,
        StPressed2 = 3'd4
    } state_e;

    localparam int unsigned DefLongCycles = 24_000_000;
    localparam int unsigned DefGapCycles  = 3_600_000;
    localparam int unsigned DefCntW       = 25;

endpackage

// File: rtl/btn_event_classifier_sat_counter.sv
// Up-counter with synchronous active-low reset, synchronous clear and an
// increment that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    output logic [Width-1:0] o_cnt
);

    logic [Width-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/btn_event_classifier.sv
// Turns a debounced button level into one-cycle press/release/click/
// double-click/long-press pulses; all outputs registered.
module btn_event_classifier
    import btn_event_classifier_pkg::*;
#(
    parameter int unsigned LONG_CYCLES = DefLongCycles,
    parameter int unsigned GAP_CYCLES  = DefGapCycles,
    parameter int unsigned CNT_W       = DefCntW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level_o,
    output logic press_o,
    output logic release_o,
    output logic click_o,
    output logic double_o,
    output logic long_o
);

    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("LONG_CYCLES must be >= 2");
    end
    if (GAP_CYCLES < 2) begin : g_bad_gap
        $error("GAP_CYCLES must be >= 2");
    end
    if (((LONG_CYCLES - 1) >> CNT_W) != 0 || ((GAP_CYCLES - 1) >> CNT_W) != 0) begin : g_bad_w
        $error("CNT_W too narrow for the thresholds");
    end

    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYCLES - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic             r_btn_q;
    logic             w_rise;
    logic             w_fall;
    logic             w_cnt_clr;
    logic [CNT_W-1:0] w_cnt;
    logic             w_click;
    logic             w_double;
    logic             w_long;
    logic             r_press;
    logic             r_release;
    logic             r_click;
    logic             r_double;
    logic             r_long;

    assign w_rise    = btn_in & ~r_btn_q;
    assign w_fall    = ~btn_in & r_btn_q;
    // Time in the current state: restarts on every transition.
    assign w_cnt_clr = (w_state_next != r_state);

    sat_counter #(
        .Width (CNT_W)
    ) u_cnt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clr   (w_cnt_clr),
        .o_cnt   (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Edges take priority over timeouts in every state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_rise) w_state_next = StPressed;
            end
            StPressed: begin
                if (w_fall)                w_state_next = StGap;
                else if (w_cnt == LongLast) w_state_next = StHeld;
            end
            StHeld: begin
                if (w_fall) w_state_next = StIdle;
            end
            StGap: begin
                if (w_rise)                w_state_next = StPressed2;
                else if (w_cnt == GapLast) w_state_next = StIdle;
            end
            StPressed2: begin
                if (w_fall)                w_state_next = StIdle;
                else if (w_cnt == LongLast) w_state_next = StHeld;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_click  = (r_state == StGap) && !w_rise && (w_cnt == GapLast);
        w_double = (r_state == StPressed2) && w_fall;
        w_long   = ((r_state == StPressed) || (r_state == StPressed2)) && !w_fall
                   && (w_cnt == LongLast);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btn_q   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_click   <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_btn_q   <= btn_in;
            r_press   <= w_rise;
            r_release <= w_fall;
            r_click   <= w_click;
            r_double  <= w_double;
            r_long    <= w_long;
        end
    end

    assign btn_level_o = r_btn_q;
    assign press_o     = r_press;
    assign release_o   = r_release;
    assign click_o     = r_click;
    assign double_o    = r_double;
    assign long_o      = r_long;

endmodule

// File: tb/tb_btn_event_classifier.sv
// Directed bench for btn_event_classifier with LONG=8, GAP=4, CNT_W=4.
module tb_btn_event_classifier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_in = 1'b0;
    logic btn_level_o, press_o, release_o, click_o, double_o, long_o;

    int n_checks = 0;
    int n_pass = 0;

    int cyc = 0;
    int n_press = 0, n_release = 0, n_click = 0, n_double = 0, n_long = 0, n_multi = 0;
    int t_press = 0, t_release = 0, t_click = 0, t_double = 0, t_long = 0;
    int b_press, b_release, b_click, b_double, b_long;

    btn_event_classifier #(
        .LONG_CYCLES (8),
        .GAP_CYCLES  (4),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .btn_level_o (btn_level_o),
        .press_o     (press_o),
        .release_o   (release_o),
        .click_o     (click_o),
        .double_o    (double_o),
        .long_o      (long_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle; t_* hold the edge index of the last pulse.
    always @(negedge clk) begin
        if (press_o)   begin n_press++;   t_press   = cyc; end
        if (release_o) begin n_release++; t_release = cyc; end
        if (click_o)   begin n_click++;   t_click   = cyc; end
        if (double_o)  begin n_double++;  t_double  = cyc; end
        if (long_o)    begin n_long++;    t_long    = cyc; end
        if (int'(click_o) + int'(double_o) + int'(long_o) > 1) n_multi++;
    end

    task automatic drive(input logic b, input int n);
        repeat (n) begin
            btn_in = b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        b_press = n_press; b_release = n_release; b_click = n_click;
        b_double = n_double; b_long = n_long;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        btn_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({btn_level_o, press_o, release_o, click_o, double_o, long_o} !== 6'b0)
            $display("FAIL reset_outputs: got %b want 000000",
                     {btn_level_o, press_o, release_o, click_o, double_o, long_o});
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        snap();
        drive(1'b0, 20);
        n_checks++;
        if ((n_press - b_press) + (n_release - b_release) + (n_click - b_click)
            + (n_double - b_double) + (n_long - b_long) !== 0)
            $display("FAIL reset_quiet: got %0d pulses want 0",
                     (n_press - b_press) + (n_release - b_release) + (n_click - b_click)
                     + (n_double - b_double) + (n_long - b_long));
        else n_pass++;
    endtask

    task automatic test_level();
        drive(1'b1, 1);
        @(negedge clk);
        n_checks++;
        if ({btn_level_o, press_o} !== 2'b11)
            $display("FAIL level_rise: got level,press=%b want 11", {btn_level_o, press_o});
        else n_pass++;
        drive(1'b0, 1);
        @(negedge clk);
        n_checks++;
        if ({btn_level_o, release_o} !== 2'b01)
            $display("FAIL level_fall: got level,release=%b want 01", {btn_level_o, release_o});
        else n_pass++;
        drive(1'b0, 10);
    endtask

    task automatic test_single_click();
        snap();
        drive(1'b1, 3);
        drive(1'b0, 10);
        n_checks++;
        if ({n_press - b_press, n_release - b_release, n_click - b_click} !== {32'd1, 32'd1, 32'd1})
            $display("FAIL click_counts: got p=%0d r=%0d c=%0d want 1 1 1",
                     n_press - b_press, n_release - b_release, n_click - b_click);
        else n_pass++;
        n_checks++;
        if (t_release - t_press !== 3)
            $display("FAIL click_hold: got %0d want 3", t_release - t_press);
        else n_pass++;
        n_checks++;
        if (t_click - t_release !== 4)
            $display("FAIL click_latency: got %0d want 4", t_click - t_release);
        else n_pass++;
        n_checks++;
        if ((n_double - b_double) + (n_long - b_long) !== 0)
            $display("FAIL click_no_other: got %0d want 0", (n_double - b_double) + (n_long - b_long));
        else n_pass++;
    endtask

    task automatic test_double_click();
        snap();
        drive(1'b1, 2); drive(1'b0, 2); drive(1'b1, 2); drive(1'b0, 10);
        n_checks++;
        if ({n_press - b_press, n_release - b_release, n_double - b_double}
            !== {32'd2, 32'd2, 32'd1})
            $display("FAIL double_counts: got p=%0d r=%0d d=%0d want 2 2 1",
                     n_press - b_press, n_release - b_release, n_double - b_double);
        else n_pass++;
        n_checks++;
        if (t_double !== t_release)
            $display("FAIL double_timing: got %0d want %0d", t_double, t_release);
        else n_pass++;
        n_checks++;
        if ((n_click - b_click) + (n_long - b_long) !== 0)
            $display("FAIL double_no_other: got %0d want 0", (n_click - b_click) + (n_long - b_long));
        else n_pass++;
    endtask

    task automatic test_long_press();
        snap();
        drive(1'b1, 20);
        n_checks++;
        if (n_long - b_long !== 1)
            $display("FAIL long_count: got %0d want 1", n_long - b_long);
        else n_pass++;
        n_checks++;
        if (t_long - t_press !== 8)
            $display("FAIL long_latency: got %0d want 8", t_long - t_press);
        else n_pass++;
        drive(1'b0, 10);
        n_checks++;
        if ({n_release - b_release, n_click - b_click, n_double - b_double}
            !== {32'd1, 32'd0, 32'd0})
            $display("FAIL long_release: got r=%0d c=%0d d=%0d want 1 0 0",
                     n_release - b_release, n_click - b_click, n_double - b_double);
        else n_pass++;
    endtask

    task automatic test_boundaries();
        // Fall coincides with the long threshold: click path.
        snap();
        drive(1'b1, 8); drive(1'b0, 10);
        n_checks++;
        if ({n_click - b_click, n_long - b_long} !== {32'd1, 32'd0})
            $display("FAIL bound_hold8: got c=%0d l=%0d want 1 0", n_click - b_click, n_long - b_long);
        else n_pass++;
        // One cycle longer reaches the threshold.
        snap();
        drive(1'b1, 9); drive(1'b0, 10);
        n_checks++;
        if ({n_click - b_click, n_long - b_long} !== {32'd0, 32'd1})
            $display("FAIL bound_hold9: got c=%0d l=%0d want 0 1", n_click - b_click, n_long - b_long);
        else n_pass++;
        // Rise coincides with the gap timeout: double path.
        snap();
        drive(1'b1, 2); drive(1'b0, 4); drive(1'b1, 2); drive(1'b0, 10);
        n_checks++;
        if ({n_click - b_click, n_double - b_double} !== {32'd0, 32'd1})
            $display("FAIL bound_gap4: got c=%0d d=%0d want 0 1", n_click - b_click, n_double - b_double);
        else n_pass++;
        // Gap one cycle too long: two separate clicks.
        snap();
        drive(1'b1, 2); drive(1'b0, 5); drive(1'b1, 2); drive(1'b0, 10);
        n_checks++;
        if ({n_click - b_click, n_double - b_double} !== {32'd2, 32'd0})
            $display("FAIL bound_gap5: got c=%0d d=%0d want 2 0", n_click - b_click, n_double - b_double);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        snap();
        drive(1'b1, 2); drive(1'b0, 2); drive(1'b1, 2); drive(1'b0, 2);
        drive(1'b1, 2); drive(1'b0, 10);
        n_checks++;
        if ({n_press - b_press, n_double - b_double, n_click - b_click}
            !== {32'd3, 32'd1, 32'd1})
            $display("FAIL triple: got p=%0d d=%0d c=%0d want 3 1 1",
                     n_press - b_press, n_double - b_double, n_click - b_click);
        else n_pass++;
    endtask

    task automatic test_reset_mid_gap();
        snap();
        drive(1'b1, 3); drive(1'b0, 1);
        rst_n = 1'b0;
        drive(1'b0, 2);
        rst_n = 1'b1;
        drive(1'b0, 10);
        n_checks++;
        if ({n_release - b_release, n_click - b_click} !== {32'd1, 32'd0})
            $display("FAIL rst_gap_drop: got r=%0d c=%0d want 1 0",
                     n_release - b_release, n_click - b_click);
        else n_pass++;
        snap();
        drive(1'b1, 3); drive(1'b0, 10);
        n_checks++;
        if ({n_click - b_click, t_click - t_release} !== {32'd1, 32'd4})
            $display("FAIL rst_gap_fresh: got c=%0d lat=%0d want 1 4",
                     n_click - b_click, t_click - t_release);
        else n_pass++;
    endtask

    task automatic test_reset_held_high();
        rst_n = 1'b0;
        drive(1'b1, 3);
        @(negedge clk);
        n_checks++;
        if (press_o !== 1'b0)
            $display("FAIL rst_held_in_reset: got press=%b want 0", press_o);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (press_o !== 1'b1)
            $display("FAIL rst_held_press: got press=%b want 1", press_o);
        else n_pass++;
        drive(1'b0, 12);
        n_checks++;
        if (n_multi !== 0)
            $display("FAIL exclusive: got %0d overlapping cycles want 0", n_multi);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_level();
        test_single_click();
        test_double_click();
        test_long_press();
        test_boundaries();
        test_back_to_back();
        test_reset_mid_gap();
        test_reset_held_high();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
